// File: rtl/ctrl_sequencer.sv
// ctrl_sequencer: instruction sequencer for the 8-bit microprocessor.
// Fetches two-byte instructions (opcode, operand), decodes them, performs the
// operand read or store on the shared req/ack memory port, and strobes the
// ALU via Exec. Owns the program counter.
// Optional build macro CTRL_SEQ_BUS_TIMEOUT_EN: abort a memory access that
// has waited 16 cycles without mem_ack and enter ERROR.
module ctrl_sequencer #(
  parameter int WIDTH      = 8,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  arst,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_rd,
  output logic                  mem_wr,
  output logic [WIDTH-1:0]      mem_wdata,
  input  logic [WIDTH-1:0]      mem_rdata,
  input  logic                  mem_ack,
  input  logic [WIDTH-1:0]      AR,
  output logic [WIDTH-1:0]      IR,
  output logic [WIDTH-1:0]      IBR,
  output logic [WIDTH-1:0]      MBR,
  output logic                  Exec,
  output logic [ADDR_WIDTH-1:0] PC,
  output logic                  halted,
  output logic                  error
);

  // Opcode map: bits [3:0] select the operation, bit 4 selects the operand
  // kind (1 = memory address, 0 = immediate), upper bits must be zero.
  localparam logic [3:0] OP_NOP   = 4'h0;
  localparam logic [3:0] OP_LOAD  = 4'h1;
  localparam logic [3:0] OP_ADD   = 4'h2;
  localparam logic [3:0] OP_SUB   = 4'h3;
  localparam logic [3:0] OP_AND   = 4'h4;
  localparam logic [3:0] OP_OR    = 4'h5;
  localparam logic [3:0] OP_XOR   = 4'h6;
  localparam logic [3:0] OP_STORE = 4'h8;
  localparam logic [3:0] OP_JMP   = 4'h9;
  localparam logic [3:0] OP_HALT  = 4'hF;
  localparam logic       OPER2_X  = 1'b1;

  localparam logic [2:0] S_FETCH_OP  = 3'd0;
  localparam logic [2:0] S_FETCH_ARG = 3'd1;
  localparam logic [2:0] S_DECODE    = 3'd2;
  localparam logic [2:0] S_READ_MEM  = 3'd3;
  localparam logic [2:0] S_WRITE_MEM = 3'd4;
  localparam logic [2:0] S_EXEC      = 3'd5;
  localparam logic [2:0] S_HALT      = 3'd6;
  localparam logic [2:0] S_ERROR     = 3'd7;

  logic [2:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0]      ir_q, ir_d;
  logic [WIDTH-1:0]      ibr_q, ibr_d;
  logic [WIDTH-1:0]      mbr_q, mbr_d;
  logic                  rd_q, rd_d;
  logic                  wr_q, wr_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [WIDTH-1:0]      wdata_q, wdata_d;
`ifdef CTRL_SEQ_BUS_TIMEOUT_EN
  logic [3:0]            to_q, to_d;
`endif

  logic                  pending;
  logic                  acked;
  logic [3:0]            op;
  logic                  oper_x;
  logic                  upper_ok;
  logic [ADDR_WIDTH-1:0] pc_inc;
  logic [ADDR_WIDTH-1:0] ibr_addr;

  assign pending  = rd_q | wr_q;
  // An ack with nothing outstanding is ignored.
  assign acked    = pending & mem_ack;
  assign op       = ir_q[3:0];
  assign oper_x   = ir_q[4];
  assign upper_ok = (ir_q[WIDTH-1:5] == '0);
  assign pc_inc   = pc_q + ADDR_WIDTH'(1);
  assign ibr_addr = ibr_q[ADDR_WIDTH-1:0];

  // Next-state, program counter and memory-request sequencing.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    ibr_d   = ibr_q;
    mbr_d   = mbr_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    case (state_q)
      S_FETCH_OP: begin
        if (!pending) begin
          // Only reached straight after reset: start the opcode read.
          rd_d   = 1'b1;
          addr_d = pc_q;
        end else if (acked) begin
          // Chain the operand read onto the same edge to avoid a bubble.
          ir_d    = mem_rdata;
          pc_d    = pc_inc;
          addr_d  = pc_inc;
          state_d = S_FETCH_ARG;
        end
      end
      S_FETCH_ARG: begin
        if (acked) begin
          ibr_d   = mem_rdata;
          pc_d    = pc_inc;
          rd_d    = 1'b0;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        state_d = S_ERROR;
        if (upper_ok) begin
          case (op)
            OP_LOAD, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
              if (oper_x == OPER2_X) begin
                rd_d    = 1'b1;
                addr_d  = ibr_addr;
                state_d = S_READ_MEM;
              end else begin
                state_d = S_EXEC;
              end
            end
            OP_STORE: begin
              if (oper_x == OPER2_X) begin
                wr_d    = 1'b1;
                addr_d  = ibr_addr;
                wdata_d = AR;
                state_d = S_WRITE_MEM;
              end
            end
            OP_JMP: begin
              if (oper_x != OPER2_X) begin
                pc_d    = ibr_addr;
                rd_d    = 1'b1;
                addr_d  = ibr_addr;
                state_d = S_FETCH_OP;
              end
            end
            OP_NOP: begin
              if (oper_x != OPER2_X) begin
                rd_d    = 1'b1;
                addr_d  = pc_q;
                state_d = S_FETCH_OP;
              end
            end
            OP_HALT: begin
              if (oper_x != OPER2_X) state_d = S_HALT;
            end
            default: state_d = S_ERROR;
          endcase
        end
      end
      S_READ_MEM: begin
        if (acked) begin
          mbr_d   = mem_rdata;
          rd_d    = 1'b0;
          state_d = S_EXEC;
        end
      end
      S_WRITE_MEM: begin
        if (acked) begin
          wr_d    = 1'b0;
          rd_d    = 1'b1;
          addr_d  = pc_q;
          state_d = S_FETCH_OP;
        end
      end
      S_EXEC: begin
        rd_d    = 1'b1;
        addr_d  = pc_q;
        state_d = S_FETCH_OP;
      end
      default: begin
        // HALT and ERROR are terminal until reset.
        state_d = state_q;
      end
    endcase
`ifdef CTRL_SEQ_BUS_TIMEOUT_EN
    // The counter restarts whenever an ack closes an access, so every new
    // request begins at zero; an ack in the 16th cycle wins.
    to_d = 4'd0;
    if (pending && !mem_ack) begin
      to_d = to_q + 4'd1;
      if (to_q == 4'd15) begin
        rd_d    = 1'b0;
        wr_d    = 1'b0;
        state_d = S_ERROR;
      end
    end
`endif
  end

  // State and datapath registers; reset overrides any in-flight access.
  always_ff @(posedge clk) begin
    if (arst) begin
      state_q <= S_FETCH_OP;
      pc_q    <= '0;
      ir_q    <= '0;
      ibr_q   <= '0;
      mbr_q   <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
`ifdef CTRL_SEQ_BUS_TIMEOUT_EN
      to_q    <= 4'd0;
`endif
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      ibr_q   <= ibr_d;
      mbr_q   <= mbr_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
`ifdef CTRL_SEQ_BUS_TIMEOUT_EN
      to_q    <= to_d;
`endif
    end
  end

  assign mem_addr  = addr_q;
  assign mem_rd    = rd_q;
  assign mem_wr    = wr_q;
  assign mem_wdata = wdata_q;
  assign IR        = ir_q;
  assign IBR       = ibr_q;
  assign MBR       = mbr_q;
  assign PC        = pc_q;
  assign Exec      = (state_q == S_EXEC);
  assign halted    = (state_q == S_HALT);
  assign error     = (state_q == S_ERROR);

endmodule

// File: doc/ctrl_sequencer.md
Name: ctrl_sequencer

Overview:
- Instruction sequencer for the 8-bit microprocessor; drives the ALU's `Exec`, `IR`, `IBR` and `MBR` inputs and reads back `AR` for stores.
- Runs a Fetch / Decode / Read Memory / Write Memory / Execute / Error FSM.
- Owns the program counter and the single shared memory port, which uses a req/ack handshake.
- Every instruction is two bytes: opcode, then operand (immediate value or memory address).

Parameters:
- WIDTH, 8, data/instruction width
- ADDR_WIDTH, 8, memory address width; PC wraps modulo 2^ADDR_WIDTH

Ports:
- clk  in  1  clock
- arst  in  1  reset, synchronous, active-high
- mem_addr  out  ADDR_WIDTH  memory address
- mem_rd  out  1  read request
- mem_wr  out  1  write request
- mem_wdata  out  WIDTH  write data (AR)
- mem_rdata  in  WIDTH  read data, valid in the mem_ack cycle
- mem_ack  in  1  access complete
- AR  in  WIDTH  accumulator from ALU
- IR  out  WIDTH  instruction register
- IBR  out  WIDTH  immediate/operand buffer
- MBR  out  WIDTH  memory buffer
- Exec  out  1  one-cycle ALU execute strobe
- PC  out  ADDR_WIDTH  program counter
- halted  out  1  HALT executed
- error  out  1  sticky illegal-opcode/bus error

Behaviour:
- Reset (arst=1 at posedge clk): state=FETCH_OP, PC=0, IR=IBR=MBR=0, mem_rd=mem_wr=0, mem_addr=0, mem_wdata=0, Exec=0, halted=0, error=0. Reset has priority over everything, including an in-flight access; a mem_ack arriving after reset is ignored.
- Memory handshake:
  - Request: mem_rd or mem_wr rises with mem_addr (and mem_wdata) registered the same cycle; all are held stable until a cycle with mem_ack=1.
  - Completion: in the mem_ack cycle, read data is captured and the request drops on the next edge. At most one request is outstanding; mem_rd and mem_wr are never high together.
  - Ignored ack: mem_ack while no request is pending is ignored.
- States:
  - FETCH_OP: read mem[PC] into IR; PC+1 on ack; go to FETCH_ARG.
  - FETCH_ARG: read mem[PC] into IBR; PC+1 on ack; go to DECODE.
  - DECODE (1 cycle), by opcode class from the shared opcode defines:
    - ALU/LOAD _X variants (operand-bit = OPER2_X): go to READ_MEM.
    - ALU/LOAD _I variants: go to EXEC.
    - STORE_X: go to WRITE_MEM.
    - JMP_I: PC=IBR[ADDR_WIDTH-1:0]; go to FETCH_OP.
    - NOP: go to FETCH_OP.
    - HALT: halted=1; go to HALT.
    - Any other opcode: error=1; go to ERROR.
  - READ_MEM: read mem[IBR] into MBR; go to EXEC.
  - WRITE_MEM: write AR to mem[IBR]; go to FETCH_OP on ack. Exec is not pulsed.
  - EXEC: Exec=1 for exactly one cycle, with IR/IBR/MBR stable; go to FETCH_OP. The ALU updates AR and flags on that edge.
  - HALT, ERROR: terminal until reset; no memory requests, Exec=0.
- Latency with zero-wait memory (ack in the first request cycle):
  - _I ALU op: 4 cycles (FETCH_OP, FETCH_ARG, DECODE, EXEC).
  - _X ALU op: 5 cycles.
  - STORE_X: 4 cycles.
  - JMP/NOP: 3 cycles.
- Wrap-around: PC increments 0xFF to 0x00 (ADDR_WIDTH=8). An instruction straddling the top fetches its operand from address 0.
- MBR is only written in READ_MEM; it holds its value otherwise.

Optional Feature:
- Macro: CTRL_SEQ_BUS_TIMEOUT_EN.
- Defined:
  - A counter, cleared on each new request, counts cycles with a request pending and no mem_ack.
  - On reaching 16 cycles: drop the request, set error=1, go to ERROR.
  - An ack arriving on the 16th cycle wins over the timeout.
- Undefined: waits indefinitely for mem_ack; no counter logic present.

Test Plan:
- Reset, then mem holds {LOAD_I, 0x5A} at 0x00 with zero-wait ack -> IR=LOAD_I, IBR=0x5A; Exec pulses once in cycle 4; PC=0x02.
- {ADD_X, 0x80}, mem[0x80]=0x11, ack delayed 3 cycles per access -> mem_rd held with mem_addr stable throughout; MBR=0x11 before Exec; Exec at cycle 5+9; PC=0x02.
- {STORE_X, 0x40} with AR=0xC3 -> one write: mem_addr=0x40, mem_wdata=0xC3, mem_wr held until ack; Exec never asserted.
- {JMP_I, 0x10} then {HALT, 0x00} at 0x10 -> next fetch address 0x10; then halted=1 and no further mem_rd.
- Illegal opcode 0xFF -> error=1, FSM frozen; assert arst mid-read on the next run -> all outputs return to reset values the following cycle and fetch restarts at 0x00.
- With CTRL_SEQ_BUS_TIMEOUT_EN, mem_ack tied 0 after reset -> mem_rd high 16 cycles, then mem_rd=0, error=1; without the macro, mem_rd stays high indefinitely.
